// File: rtl/wall_layout_ctrl_pkg.sv
// Shared types, sizes and reset layout for the wall placement controller.
// Clamp helper is only referenced when WALL_CLAMP_EN is defined.
package wall_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        PENDING,
        APPLY
    } state_t;

    typedef logic [9:0] coord_t;

    localparam int unsigned NUM_WALLS = 4;
    localparam int unsigned X_MAX     = 639;
    localparam int unsigned Y_MAX     = 479;
    localparam int unsigned HOR_W     = 64;
    localparam int unsigned HOR_H     = 32;
    localparam int unsigned VERT_W    = 32;
    localparam int unsigned VERT_H    = 64;

    localparam coord_t DEF_X [NUM_WALLS] = '{10'd50,  10'd400, 10'd320, 10'd600};
    localparam coord_t DEF_Y [NUM_WALLS] = '{10'd100, 10'd200, 10'd240, 10'd400};

    // Bit i set: wall i is horizontal (walls 1 and 3).
    localparam logic [NUM_WALLS-1:0] IS_HOR = 4'b0101;

    function automatic coord_t clamp_coord(input logic [1:0] idx, input logic is_y,
                                           input coord_t v);
        coord_t lim;
        if (is_y)
            lim = IS_HOR[idx] ? coord_t'(Y_MAX - HOR_H) : coord_t'(Y_MAX - VERT_H);
        else
            lim = IS_HOR[idx] ? coord_t'(X_MAX - HOR_W) : coord_t'(X_MAX - VERT_W);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/wall_layout_ctrl_if.sv
// Board-side bundle: switches, buttons, frame strobe and wall coordinate outputs.
interface wall_layout_if;
    import wall_pkg::*;

    coord_t     SW;
    logic       edit_start;
    logic       load_x;
    logic       load_y;
    logic       next_wall;
    logic       commit;
    logic       abort;
    logic       frame_clk;
    coord_t     X1, X2, X3, X4;
    coord_t     Y1, Y2, Y3, Y4;
    logic [1:0] sel_wall;
    logic       editing;
    logic       pending;

    modport master (
        output SW, edit_start, load_x, load_y, next_wall, commit, abort, frame_clk,
        input  X1, X2, X3, X4, Y1, Y2, Y3, Y4, sel_wall, editing, pending
    );

    modport slave (
        input  SW, edit_start, load_x, load_y, next_wall, commit, abort, frame_clk,
        output X1, X2, X3, X4, Y1, Y2, Y3, Y4, sel_wall, editing, pending
    );
endinterface

// File: rtl/wall_layout_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh <= '0;
        else        sh <= {sh[1:0], din};
    end

    assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/wall_layout_ctrl.sv
// Wall placement controller: shadow edits from SW/keys, applied to active walls at a frame edge.
// Optional macro WALL_CLAMP_EN saturates loaded coordinates to keep walls on screen.
module wall_layout_ctrl
    import wall_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset_n,
    wall_layout_if.slave  bus
);
    logic p_start, p_lx, p_ly, p_next, p_commit, p_abort, p_frame;

    sync_edge u_start  (.clk(Clk), .rst_n(Reset_n), .din(bus.edit_start), .pulse(p_start));
    sync_edge u_lx     (.clk(Clk), .rst_n(Reset_n), .din(bus.load_x),     .pulse(p_lx));
    sync_edge u_ly     (.clk(Clk), .rst_n(Reset_n), .din(bus.load_y),     .pulse(p_ly));
    sync_edge u_next   (.clk(Clk), .rst_n(Reset_n), .din(bus.next_wall),  .pulse(p_next));
    sync_edge u_commit (.clk(Clk), .rst_n(Reset_n), .din(bus.commit),     .pulse(p_commit));
    sync_edge u_abort  (.clk(Clk), .rst_n(Reset_n), .din(bus.abort),      .pulse(p_abort));
    sync_edge u_frame  (.clk(Clk), .rst_n(Reset_n), .din(bus.frame_clk),  .pulse(p_frame));

    state_t     state, state_n;
    logic [1:0] sel, sel_n;
    coord_t     sx [NUM_WALLS];
    coord_t     sy [NUM_WALLS];
    coord_t     sx_n [NUM_WALLS];
    coord_t     sy_n [NUM_WALLS];
    coord_t     ax [NUM_WALLS];
    coord_t     ay [NUM_WALLS];
    coord_t     ld_x, ld_y;

`ifdef WALL_CLAMP_EN
    assign ld_x = clamp_coord(sel, 1'b0, bus.SW);
    assign ld_y = clamp_coord(sel, 1'b1, bus.SW);
`else
    assign ld_x = bus.SW;
    assign ld_y = bus.SW;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            sel   <= '0;
            for (int unsigned i = 0; i < NUM_WALLS; i++) begin
                sx[i] <= DEF_X[i];
                sy[i] <= DEF_Y[i];
                ax[i] <= DEF_X[i];
                ay[i] <= DEF_Y[i];
            end
        end else begin
            state <= state_n;
            sel   <= sel_n;
            sx    <= sx_n;
            sy    <= sy_n;
            if (state == APPLY) begin
                ax <= sx;
                ay <= sy;
            end
        end
    end

    // Loads index with the current sel, so a same-cycle next_wall does not redirect them.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        sx_n    = sx;
        sy_n    = sy;
        unique case (state)
            IDLE: if (p_start) begin
                state_n = EDIT;
                sel_n   = '0;
                sx_n    = ax;
                sy_n    = ay;
            end
            EDIT: begin
                if (p_lx)   sx_n[sel] = ld_x;
                if (p_ly)   sy_n[sel] = ld_y;
                if (p_next) sel_n = sel + 2'd1;
                if (p_abort) begin
                    state_n = IDLE;
                    sx_n    = ax;
                    sy_n    = ay;
                end else if (p_commit) begin
                    state_n = PENDING;
                end
            end
            PENDING: if (p_frame) state_n = APPLY;
            APPLY:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.X1       = ax[0];
    assign bus.X2       = ax[1];
    assign bus.X3       = ax[2];
    assign bus.X4       = ax[3];
    assign bus.Y1       = ay[0];
    assign bus.Y2       = ay[1];
    assign bus.Y3       = ay[2];
    assign bus.Y4       = ay[3];
    assign bus.sel_wall = sel;
    assign bus.editing  = (state == EDIT);
    assign bus.pending  = (state == PENDING) || (state == APPLY);
endmodule

// File: tb/tb_wall_layout_ctrl.sv
// Scoreboard bench for wall_layout_ctrl: expected output snapshots are queued per Clk edge.
module tb_wall_layout_ctrl;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [3:0][9:0]  x;
        logic [3:0][9:0]  y;
        logic [1:0]       sel;
        logic             ed;
        logic             pe;
    } snap_t;

    localparam logic [3:0][9:0] RST_X = {10'd600, 10'd320, 10'd400, 10'd50};
    localparam logic [3:0][9:0] RST_Y = {10'd400, 10'd240, 10'd200, 10'd100};

    localparam logic [6:0] B_START  = 7'b0000001;
    localparam logic [6:0] B_LX     = 7'b0000010;
    localparam logic [6:0] B_LY     = 7'b0000100;
    localparam logic [6:0] B_NEXT   = 7'b0001000;
    localparam logic [6:0] B_COMMIT = 7'b0010000;
    localparam logic [6:0] B_ABORT  = 7'b0100000;
    localparam logic [6:0] B_FRAME  = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    snap_t       q[$];

    // Reference model: mode 0 idle, 1 editing, 2 waiting for frame, 3 applying.
    int unsigned     m_mode;
    int unsigned     m_sel;
    logic [3:0][9:0] m_ax, m_ay, m_sx, m_sy;

    wall_layout_if bus ();

    wall_layout_ctrl dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ld(input int unsigned w, input bit is_y, input logic [9:0] v);
`ifdef WALL_CLAMP_EN
        int unsigned lim;
        bit hor = (w % 2) == 0;
        if (is_y) lim = hor ? 479 - 32 : 479 - 64;
        else      lim = hor ? 639 - 64 : 639 - 32;
        return (int'(v) > lim) ? 10'(lim) : v;
`else
        return v;
`endif
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.cyc = cyc;
        s.x   = {bus.X4, bus.X3, bus.X2, bus.X1};
        s.y   = {bus.Y4, bus.Y3, bus.Y2, bus.Y1};
        s.sel = bus.sel_wall;
        s.ed  = bus.editing;
        s.pe  = bus.pending;
        return s;
    endfunction

    task automatic push(input int unsigned at);
        snap_t s;
        s.cyc = at;
        s.x   = m_ax;
        s.y   = m_ay;
        s.sel = 2'(m_sel);
        s.ed  = (m_mode == 1);
        s.pe  = (m_mode >= 2);
        q.push_back(s);
    endtask

    task automatic compare(input string name, input snap_t a, input snap_t e);
        checks++;
        if (a[$bits(snap_t)-33:0] !== e[$bits(snap_t)-33:0]) begin
            failures++;
            $display("FAIL %s cyc=%0d actual X=%0d/%0d/%0d/%0d Y=%0d/%0d/%0d/%0d sel=%0d ed=%0b pe=%0b required X=%0d/%0d/%0d/%0d Y=%0d/%0d/%0d/%0d sel=%0d ed=%0b pe=%0b",
                     name, e.cyc, a.x[0], a.x[1], a.x[2], a.x[3], a.y[0], a.y[1], a.y[2], a.y[3],
                     a.sel, a.ed, a.pe, e.x[0], e.x[1], e.x[2], e.x[3], e.y[0], e.y[1], e.y[2],
                     e.y[3], e.sel, e.ed, e.pe);
        end
    endtask

    // Monitor: compares each queued snapshot on the falling edge of its target cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_snapshot actual cyc=%0d required cyc=%0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) compare("snapshot", dut_snap(), q.pop_front());
    end

    task automatic model_reset();
        m_mode = 0;
        m_sel  = 0;
        m_ax   = RST_X;
        m_ay   = RST_Y;
        m_sx   = RST_X;
        m_sy   = RST_Y;
    endtask

    task automatic model_event(input logic [6:0] b, input logic [9:0] sw, input int unsigned k);
        if (b[6]) begin
            if (m_mode == 2) begin
                m_mode = 3;
                push(k + 3);
                m_ax   = m_sx;
                m_ay   = m_sy;
                m_mode = 0;
                push(k + 4);
            end else begin
                push(k + 3);
            end
            return;
        end
        if (m_mode == 0) begin
            if (b[0]) begin
                m_mode = 1;
                m_sel  = 0;
                m_sx   = m_ax;
                m_sy   = m_ay;
            end
        end else if (m_mode == 1) begin
            if (b[1]) m_sx[m_sel] = ld(m_sel, 1'b0, sw);
            if (b[2]) m_sy[m_sel] = ld(m_sel, 1'b1, sw);
            if (b[3]) m_sel = (m_sel + 1) % 4;
            if (b[5]) begin
                m_mode = 0;
                m_sx   = m_ax;
                m_sy   = m_ay;
            end else if (b[4]) begin
                m_mode = 2;
            end
        end
        push(k + 3);
    endtask

    task automatic drive(input logic [6:0] b);
        bus.edit_start = b[0];
        bus.load_x     = b[1];
        bus.load_y     = b[2];
        bus.next_wall  = b[3];
        bus.commit     = b[4];
        bus.abort      = b[5];
        bus.frame_clk  = b[6];
    endtask

    task automatic press(input logic [6:0] b, input logic [9:0] sw, input int unsigned hold);
        int unsigned k;
        @(posedge clk);
        #1;
        k = cyc;
        bus.SW = sw;
        drive(b);
        push(k + 2);
        model_event(b, sw, k);
        repeat (hold) @(posedge clk);
        #1;
        drive('0);
        repeat (6) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        snap_t e;
        e.cyc = cyc;
        e.x   = RST_X;
        e.y   = RST_Y;
        e.sel = '0;
        e.ed  = 1'b0;
        e.pe  = 1'b0;
        compare(name, dut_snap(), e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  b;
        logic [9:0]  sw;
        drive('0);
        bus.SW = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("after_reset");

        // Edit wall 2 X and apply on a frame.
        press(B_START, 10'd0, 1);
        press(B_NEXT, 10'd0, 2);
        press(B_LX, 10'd123, 1);
        press(B_COMMIT, 10'd123, 1);
        press(B_FRAME, 10'd123, 3);

        // Same-cycle X and Y load of an over-range value on wall 1.
        press(B_START, 10'd0, 1);
        press(B_LX | B_LY, 10'd1000, 2);
        press(B_COMMIT, 10'd1000, 1);
        press(B_FRAME, 10'd1000, 1);

        // Selection wrap, then abort beating commit.
        press(B_START, 10'd0, 1);
        for (int i = 0; i < 4; i++) press(B_NEXT, 10'd0, 1);
        press(B_LX, 10'd7, 1);
        press(B_COMMIT | B_ABORT, 10'd7, 1);
        press(B_FRAME, 10'd7, 1);

        // Frames outside PENDING, buttons held while PENDING, single apply.
        press(B_FRAME, 10'd0, 2);
        press(B_START, 10'd0, 1);
        press(B_FRAME, 10'd0, 1);
        press(B_LY, 10'd300, 1);
        press(B_COMMIT, 10'd300, 1);
        press(B_START | B_LX | B_NEXT | B_ABORT, 10'd9, 8);
        press(B_FRAME, 10'd9, 4);
        press(B_FRAME, 10'd9, 1);

        for (int n = 0; n < 100; n++) begin
            sw = ($urandom_range(3) == 0) ? 10'($urandom_range(1023, 880)) : 10'($urandom_range(1023));
            if ($urandom_range(3) == 0) begin
                b = B_FRAME;
            end else begin
                b = 7'(1 << $urandom_range(5));
                if ($urandom_range(3) == 0) b = b | 7'(1 << $urandom_range(5));
            end
            press(b, sw, $urandom_range(4, 1));
        end

        // Reset while PENDING discards edits; a later frame changes nothing.
        press(B_START, 10'd0, 1);
        press(B_LX, 10'd222, 1);
        press(B_COMMIT, 10'd222, 1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_reset_pending");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        press(B_FRAME, 10'd0, 2);
        #1;
        check_reset_outputs("after_reset_frame");

        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wall_layout_ctrl.md
# wall_layout_ctrl

Runtime placement controller for the four playfield walls. Holds the active wall coordinates driving the wall renderer's X1–X4/Y1–Y4, plus a shadow copy the player edits from the switches and keys. Committed edits are applied only at a frame boundary so the renderer never draws a half-updated layout. Sits between the board I/O (SW, KEY) and the wall/collision logic; replaces the renderer's hard-coded positions.

## Interface
- NUM_WALLS, 4, wall count (fixed at 4; indices 0..3 map to walls 1..4)
- X_MAX, 639, rightmost screen column
- Y_MAX, 479, bottom screen row
- HOR_W / HOR_H, 64 / 32, horizontal wall size (walls 1, 3)
- VERT_W / VERT_H, 32 / 64, vertical wall size (walls 2, 4)

- Clk  in  1  50 MHz system clock; single clock domain
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame strobe (~60 Hz), asynchronous to Clk
- SW  in  10  coordinate value to load
- edit_start  in  1  level button; rising edge enters edit
- load_x / load_y  in  1  level buttons; rising edge loads SW into selected shadow X / Y
- next_wall  in  1  level button; rising edge advances selected wall
- commit / abort  in  1  level buttons; rising edge ends edit
- X1..X4, Y1..Y4  out  10  active wall coordinates
- sel_wall  out  2  currently selected wall index
- editing  out  1  high in EDIT
- pending  out  1  high in PENDING or APPLY

## Operation
- All button and frame_clk inputs pass through 2-flop synchronizer + rising-edge detector; only single-cycle pulses reach the FSM.
- States: IDLE, EDIT, PENDING, APPLY.
- IDLE: edit_start pulse -> EDIT, sel_wall <= 0, shadow <= active. Other pulses ignored.
- EDIT: load_x pulse -> shadowX[sel] <= clampX(sel, SW); load_y likewise for Y. next_wall -> sel_wall <= sel_wall+1, wraps 3 -> 0. commit -> PENDING. abort -> shadow <= active, IDLE.
- Same-cycle pulses in EDIT: abort beats commit; loads always use pre-increment sel_wall; load_x and load_y may both land; commit with loads commits the loaded values.
- PENDING: waits for frame_clk rise pulse -> APPLY. All buttons ignored.
- APPLY: one cycle; active <= shadow for all four walls simultaneously; -> IDLE.
- frame_clk pulses outside PENDING are ignored; commit with no changes still waits one frame.
- Clamp (unsigned 10-bit): horizontal walls X ≤ X_MAX−HOR_W (575), Y ≤ Y_MAX−HOR_H (447); vertical walls X ≤ X_MAX−VERT_W (607), Y ≤ Y_MAX−VERT_H (415). Values above limit saturate to limit.

## Timing
- Reset values: X1..X4 = 50, 400, 320, 600; Y1..Y4 = 100, 200, 240, 400; shadow equals active; sel_wall=0; editing=0; pending=0; state IDLE; synchronizer flops 0.
- Button latency: shadow/sel/state update on the 3rd Clk edge after the first edge sampling the button high.
- Frame latency: state APPLY on 3rd edge after first edge sampling frame_clk high; active outputs change on the 4th; pending drops on the 4th.
- Held button produces exactly one pulse; re-arm requires input low for ≥1 sampled cycle.
- Reset_n assertion mid-edit or mid-pending discards all shadow edits immediately (asynchronous), outputs to reset values.
- Outputs registered; no combinational path inputs -> outputs.

## Configuration
- WALL_CLAMP_EN defined: clamp rules above applied on every load.
- Undefined: SW loaded raw (0..1023); off-screen walls permitted, renderer simply draws nothing off screen.

## Structure
- Package wall_pkg: state enum (IDLE, EDIT, PENDING, APPLY), wall size constants, default X/Y arrays, per-index orientation constant (horizontal for 0, 2).
- Sub-module sync_edge: 2-flop synchronizer + rising-edge pulse, async active-low reset; instantiated once per button and for frame_clk.

## Test plan
- Reset: release Reset_n -> X1..X4 = 50/400/320/600, Y1..Y4 = 100/200/240/400, editing=0, pending=0.
- Edit wall 2: edit_start, next_wall, SW=123 load_x, commit, frame_clk pulse -> X2=123 exactly 4 edges after frame_clk sampled high; X2 unchanged before.
- Clamp (WALL_CLAMP_EN): wall 1, SW=1000 load_x and load_y same cycle -> shadow X1=575, Y1=447; undefined build -> 1000/1000.
- Wrap/priority: four next_wall pulses -> sel_wall returns 0; commit+abort same cycle -> IDLE, active unchanged.
- Frame gating: frame_clk pulses in IDLE/EDIT -> no output change; commit then hold buttons in PENDING -> ignored, single apply on next frame.
- Reset mid-PENDING: assert Reset_n low after commit -> defaults restored asynchronously, later frame_clk has no effect.
